// File: rtl/fifo_nod_stream_pkg.sv
// Shared defaults, output-stage load selector and parameter legality check
// for the parametrised NoD stream FIFO.
package fifo_nod_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Source chosen for the output register on a given cycle.
  typedef enum logic [1:0] {
    LD_HOLD,
    LD_ARRAY,
    LD_BYPASS,
    LD_DRAIN
  } load_sel_e;

  function automatic bit params_ok(input int unsigned depth, input int unsigned af_th);
    return (depth >= 2) && (af_th >= 1) && (af_th <= depth);
  endfunction

endpackage

// File: rtl/fifo_nod_stream_if.sv
// Push (wr_en/full) and pop (valid/ready) bundle of the NoD stream FIFO,
// plus occupancy and overflow status.
interface fifo_nod_stream_if
  import fifo_nod_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_FIFO_DEPTH
);
  logic [DATA_WIDTH-1:0]        din;
  logic                         wr_en;
  logic                         full;
  logic                         almost_full;
  logic [DATA_WIDTH-1:0]        dout;
  logic                         valid;
  logic                         ready;
  logic [$clog2(DEPTH+2)-1:0]   count;
  logic                         overflow;

  modport master (
    output din, wr_en, ready,
    input  full, almost_full, dout, valid, count, overflow
  );

  modport slave (
    input  din, wr_en, ready,
    output full, almost_full, dout, valid, count, overflow
  );
endinterface

// File: rtl/fifo_nod_stream_mem.sv
// Register-based storage array: one synchronous write port, one
// asynchronous read port, no reset on contents.
module nod_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_nod_stream.sv
// Synchronous FIFO with a registered valid/ready output stage, optional
// empty-FIFO bypass, almost-full threshold, occupancy count and sticky overflow.
module fifo_nod_stream
  import fifo_nod_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_FIFO_DEPTH,
  parameter int unsigned AF_TH      = DEPTH - 1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  fifo_nod_stream_if.slave  strm
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = $clog2(DEPTH + 2);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_AF   = OCC_W'(AF_TH);

  if (!params_ok(DEPTH, AF_TH)) begin : g_bad_params
    $fatal(1, "fifo_nod_stream: DEPTH must be >= 2 and AF_TH within 1..DEPTH");
  end

  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  full_q, af_q, ovf_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  push, load, arr_wr, arr_rd;
  load_sel_e             sel;

  nod_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (arr_wr),
    .waddr (wr_ptr_q),
    .wdata (strm.din),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Array contents always win over bypass so ordering stays strictly FIFO.
  always_comb begin
    push = strm.wr_en & ~full_q;
    load = ~valid_q | strm.ready;
    sel  = LD_HOLD;
    if (load) begin
      if (occ_q != '0)           sel = LD_ARRAY;
      else if (BYPASS && push)   sel = LD_BYPASS;
      else                       sel = LD_DRAIN;
    end

    arr_rd = (sel == LD_ARRAY);
    arr_wr = push & (sel != LD_BYPASS);

    occ_d = occ_q;
    case ({arr_wr, arr_rd})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    valid_d = valid_q;
    dout_d  = dout_q;
    case (sel)
      LD_ARRAY: begin
        valid_d = 1'b1;
        dout_d  = mem_rdata;
      end
      LD_BYPASS: begin
        valid_d = 1'b1;
        dout_d  = strm.din;
      end
      LD_DRAIN: valid_d = 1'b0;
      default:  ;
    endcase

    count_d = CNT_W'(occ_d) + CNT_W'(valid_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (arr_rd) rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      if (arr_wr) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      occ_q   <= occ_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      full_q  <= (occ_d == OCC_FULL);
      af_q    <= (occ_d >= OCC_AF);
      count_q <= count_d;
      ovf_q   <= ovf_q | (strm.wr_en & full_q);
    end
  end

  assign strm.full        = full_q;
  assign strm.almost_full = af_q;
  assign strm.dout        = dout_q;
  assign strm.valid       = valid_q;
  assign strm.count       = count_q;
  assign strm.overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_nod_stream.sv
// Scoreboard bench for fifo_nod_stream: bypass/non-bypass latency, fill and
// backpressure, streaming, random traffic, pointer wrap and mid-stream reset.
module tb_fifo_nod_stream;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_nod_stream_if #(.DATA_WIDTH(8), .DEPTH(4)) ifa ();
  fifo_nod_stream_if #(.DATA_WIDTH(8), .DEPTH(4)) ifb ();
  fifo_nod_stream_if #(.DATA_WIDTH(8), .DEPTH(3)) ifc ();

  fifo_nod_stream #(.DATA_WIDTH(8), .DEPTH(4), .AF_TH(3), .BYPASS(1'b1))
    u_a (.clk(clk), .rstn(rstn), .strm(ifa));
  fifo_nod_stream #(.DATA_WIDTH(8), .DEPTH(4), .AF_TH(3), .BYPASS(1'b0))
    u_b (.clk(clk), .rstn(rstn), .strm(ifb));
  fifo_nod_stream #(.DATA_WIDTH(8), .DEPTH(3), .AF_TH(2), .BYPASS(1'b1))
    u_c (.clk(clk), .rstn(rstn), .strm(ifc));

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sba[$];
  logic [7:0] sbc[$];
  logic exp_ovf_a = 1'b0;
  int pops_a = 0;

  // One clock of traffic on instance A; inputs driven #1 after the edge.
  task automatic cyc_a(input logic w, input logic [7:0] d, input logic r);
    logic hold;
    logic [7:0] held, exp;
    ifa.wr_en = w; ifa.din = d; ifa.ready = r;
    hold = ifa.valid && !r;
    held = ifa.dout;
    if (w && ifa.full) exp_ovf_a = 1'b1;
    if (w && !ifa.full) sba.push_back(d);
    if (ifa.valid && r) begin
      vectors++;
      pops_a++;
      if (sba.size() == 0) begin
        miscompares++;
        $display("FAIL pop_a: got %h, expected no data", ifa.dout);
      end else begin
        exp = sba.pop_front();
        if (ifa.dout !== exp) begin
          miscompares++;
          $display("FAIL pop_a: got %h, expected %h", ifa.dout, exp);
        end
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (ifa.count !== sba.size()) begin
      miscompares++;
      $display("FAIL count_a: got %0d, expected %0d", ifa.count, sba.size());
    end
    vectors++;
    if (ifa.overflow !== exp_ovf_a) begin
      miscompares++;
      $display("FAIL overflow_a: got %b, expected %b", ifa.overflow, exp_ovf_a);
    end
    if (hold) begin
      vectors++;
      if (ifa.valid !== 1'b1 || ifa.dout !== held) begin
        miscompares++;
        $display("FAIL hold_a: got valid=%b dout=%h, expected valid=1 dout=%h", ifa.valid, ifa.dout, held);
      end
    end
  endtask

  task automatic cyc_c(input logic w, input logic [7:0] d, input logic r);
    logic [7:0] exp;
    ifc.wr_en = w; ifc.din = d; ifc.ready = r;
    if (w && !ifc.full) sbc.push_back(d);
    if (ifc.valid && r) begin
      vectors++;
      exp = (sbc.size() != 0) ? sbc.pop_front() : 8'hxx;
      if (ifc.dout !== exp) begin
        miscompares++;
        $display("FAIL pop_c: got %h, expected %h", ifc.dout, exp);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (ifc.count !== sbc.size()) begin
      miscompares++;
      $display("FAIL count_c: got %0d, expected %0d", ifc.count, sbc.size());
    end
  endtask

  task automatic do_reset();
    ifa.wr_en = 1'b0; ifa.din = '0; ifa.ready = 1'b0;
    ifb.wr_en = 1'b0; ifb.din = '0; ifb.ready = 1'b0;
    ifc.wr_en = 1'b0; ifc.din = '0; ifc.ready = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    sba.delete(); sbc.delete();
    exp_ovf_a = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({ifa.valid, ifa.dout, ifa.full, ifa.almost_full, ifa.count, ifa.overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_a: got v=%b d=%h f=%b af=%b c=%0d o=%b, expected all 0",
               ifa.valid, ifa.dout, ifa.full, ifa.almost_full, ifa.count, ifa.overflow);
    end
    vectors++;
    if ({ifb.valid, ifb.count, ifb.full} !== '0) begin
      miscompares++;
      $display("FAIL reset_b: got v=%b c=%0d f=%b, expected 0", ifb.valid, ifb.count, ifb.full);
    end
  endtask

  task automatic test_bypass_latency();
    cyc_a(1'b1, 8'hA5, 1'b1);
    vectors++;
    if (ifa.valid !== 1'b1 || ifa.dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL bypass_a_edge0: got v=%b d=%h, expected v=1 d=a5", ifa.valid, ifa.dout);
    end
    cyc_a(1'b0, 8'h00, 1'b1);
    vectors++;
    if (ifa.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_a_edge1: got v=%b, expected 0", ifa.valid);
    end
    // Non-bypass instance: data lands in the array first.
    ifb.wr_en = 1'b1; ifb.din = 8'hA5; ifb.ready = 1'b1;
    @(posedge clk); #1;
    ifb.wr_en = 1'b0;
    vectors++;
    if (ifb.valid !== 1'b0 || ifb.count !== 3'd1) begin
      miscompares++;
      $display("FAIL nobypass_edge0: got v=%b c=%0d, expected v=0 c=1", ifb.valid, ifb.count);
    end
    @(posedge clk); #1;
    vectors++;
    if (ifb.valid !== 1'b1 || ifb.dout !== 8'hA5) begin
      miscompares++;
      $display("FAIL nobypass_edge1: got v=%b d=%h, expected v=1 d=a5", ifb.valid, ifb.dout);
    end
    @(posedge clk); #1;
    vectors++;
    if (ifb.valid !== 1'b0 || ifb.count !== 3'd0) begin
      miscompares++;
      $display("FAIL nobypass_edge2: got v=%b c=%0d, expected v=0 c=0", ifb.valid, ifb.count);
    end
  endtask

  task automatic test_fill();
    logic [2:0] exp_af [6];
    exp_af = '{3'b100, 3'b100, 3'b100, 3'b110, 3'b111, 3'b111}; // {valid, af, full}
    for (int i = 0; i < 6; i++) begin
      cyc_a(1'b1, 8'(i + 1), 1'b0);
      vectors++;
      if ({ifa.valid, ifa.almost_full, ifa.full} !== exp_af[i]) begin
        miscompares++;
        $display("FAIL fill_flags_%0d: got %b, expected %b", i + 1,
                 {ifa.valid, ifa.almost_full, ifa.full}, exp_af[i]);
      end
    end
    vectors++;
    if (ifa.dout !== 8'd1 || ifa.count !== 3'd5 || ifa.overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_state: got d=%h c=%0d o=%b, expected d=01 c=5 o=1", ifa.dout, ifa.count, ifa.overflow);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (ifa.valid !== 1'b1 || ifa.dout !== 8'(i + 1)) begin
        miscompares++;
        $display("FAIL drain_%0d: got v=%b d=%h, expected v=1 d=%h", i, ifa.valid, ifa.dout, 8'(i + 1));
      end
      cyc_a(1'b0, 8'h00, 1'b1);
    end
    vectors++;
    if (ifa.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_end: got v=%b, expected 0", ifa.valid);
    end
  endtask

  task automatic test_stream();
    int p0;
    logic seen_full;
    p0 = pops_a;
    seen_full = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc_a(1'b1, 8'(i), 1'b1);
      seen_full |= ifa.full;
      vectors++;
      if (ifa.valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_bubble_%0d: got v=%b, expected 1", i, ifa.valid);
      end
    end
    repeat (3) cyc_a(1'b0, 8'h00, 1'b1);
    vectors++;
    if (pops_a - p0 !== 100 || seen_full !== 1'b0) begin
      miscompares++;
      $display("FAIL stream: got pops=%0d full_seen=%b, expected pops=100 full_seen=0", pops_a - p0, seen_full);
    end
  endtask

  task automatic test_random();
    logic w;
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 1) == 1) && !ifa.full;
      cyc_a(w, 8'($urandom), $urandom_range(0, 1) == 1);
    end
    repeat (8) cyc_a(1'b0, 8'h00, 1'b1);
    vectors++;
    if (sba.size() !== 0) begin
      miscompares++;
      $display("FAIL random_drain: got %0d left, expected 0", sba.size());
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) cyc_c(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 20; i++) cyc_c(1'b1, 8'(8'h20 + i), 1'b1);
    repeat (5) cyc_c(1'b0, 8'h00, 1'b1);
    vectors++;
    if (sbc.size() !== 0 || ifc.valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_drain: got left=%0d v=%b, expected 0 and 0", sbc.size(), ifc.valid);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    for (int i = 0; i < 3; i++) cyc_a(1'b1, 8'(8'h31 + i), 1'b0);
    vectors++;
    if (ifa.count !== 3'd3 || ifa.valid !== 1'b1) begin
      miscompares++;
      $display("FAIL premid: got c=%0d v=%b, expected c=3 v=1", ifa.count, ifa.valid);
    end
    ifa.wr_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({ifa.valid, ifa.count, ifa.full, ifa.overflow, ifa.dout} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b c=%0d f=%b o=%b d=%h, expected all 0",
               ifa.valid, ifa.count, ifa.full, ifa.overflow, ifa.dout);
    end
    @(posedge clk); #1 rstn = 1'b1;
    sba.delete();
    exp_ovf_a = 1'b0;
    p0 = pops_a;
    cyc_a(1'b1, 8'h77, 1'b1);
    repeat (3) cyc_a(1'b0, 8'h00, 1'b1);
    vectors++;
    if (pops_a - p0 !== 1) begin
      miscompares++;
      $display("FAIL post_reset_pops: got %0d, expected 1", pops_a - p0);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_bypass_latency();
    test_fill();
    do_reset();
    test_stream();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_nod_stream.md
Name: fifo_nod_stream

Overview:
- Parametrised successor of the fixed-width NoD FIFO wrapper: synchronous FIFO with a registered valid/ready output stage.
- Adds configurable width and depth, a bypass mode, almost-full threshold, occupancy count and sticky overflow flag.
- Sits on NoD router input/output buffers and in the bypass_controller data path.
- Writes use a wr_en/full push interface; reads are a standard valid/ready stream.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH: payload width in bits.
- DEPTH, default `FIFO_DEPTH: storage-array entries, >=2; need not be a power of two.
- AF_TH, default DEPTH-1: almost_full asserts when array occupancy >= AF_TH; legal range 1..DEPTH.
- BYPASS, default 1: 1 lets a write into an empty block load the output register directly; 0 always routes data through the array.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- din  in  DATA_WIDTH  write data.
- wr_en  in  1  push request; accepted iff full==0.
- full  out  1  array occupancy == DEPTH.
- almost_full  out  1  array occupancy >= AF_TH.
- dout  out  DATA_WIDTH  output-register data.
- valid  out  1  output register holds data.
- ready  in  1  consumer accepts; a pop occurs when valid&ready.
- count  out  $clog2(DEPTH+2)  array occupancy + valid (total items held, 0..DEPTH+1).
- overflow  out  1  sticky; set when wr_en&full; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): rd/wr pointers=0, array occupancy=0, valid=0, dout=0, full=0, almost_full=0, count=0, overflow=0.
- All outputs are registered; no combinational path from ready or wr_en to any output.
- Write acceptance: push = wr_en & ~full, using the registered full. A write while full is dropped and sets overflow, even if a pop happens in the same cycle.
- Output-stage load condition: load = ~valid | ready.
- When load is true, in priority order:
  - (a) array non-empty: dout <= array[rd_ptr]; rd_ptr advances; valid <= 1.
  - (b) array empty & BYPASS & push: dout <= din; valid <= 1; the array is not written.
  - (c) otherwise: valid <= 0.
- Rule (a) takes priority over (b), so ordering is strictly FIFO.
- When load is false, dout and valid hold. dout must stay stable while valid & ~ready.
- Array write: on push, except in case (b): array[wr_ptr] <= din; wr_ptr advances.
- Pointer wrap: a pointer equal to DEPTH-1 wraps to 0.
- Simultaneous array write and array read: occupancy is unchanged. This is legal even when occupancy==DEPTH-1 or when occupancy==1 with a concurrent refill.
- Array occupancy: +1 on array write, -1 on array read. full and almost_full are derived from the next occupancy and registered.
- count is registered with next value = next array occupancy + next valid.
- Latency from a write edge k into an empty block:
  - BYPASS=1: valid high after edge k.
  - BYPASS=0: valid high after edge k+1.
- Throughput: one push and one pop per cycle sustained, with no bubbles under continuous ready.
- Total capacity is DEPTH+1 items: DEPTH in the array plus 1 in the output register.
- Reset asserted mid-operation: all contents are discarded immediately and outputs return to reset values asynchronously.
- Simulation assertions: AF_TH out of range or DEPTH<2 triggers $fatal at elaboration.

Decomposition:
- Shared header param.vh supplies the DATA_WIDTH, FIFO_DEPTH and FIFO_DEPTH_LOG defaults; nothing new is added to it.
- Count and pointer widths are local parameters derived with $clog2.
- One sub-module, nod_fifo_mem:
  - register-based DEPTH x DATA_WIDTH array;
  - one synchronous write port;
  - one asynchronous read port addressed by rd_ptr;
  - no reset on storage.
- Pointers, occupancy, flags and the output stage stay in fifo_nod_stream.

Test Plan:
- Bypass latency: BYPASS=1, ready=1, single write 0xA5 at edge 0 -> valid=1 and dout=0xA5 after edge 0, valid=0 after edge 1, count returns to 0. Same stimulus with BYPASS=0 -> valid first high after edge 1.
- Fill and backpressure: DEPTH=4, AF_TH=3, ready=0, writes 1..6 ->
  - valid after first write, dout=1;
  - almost_full after 4th write;
  - full after 5th write;
  - 6th write dropped, overflow=1, count=5.
  - Then ready=1 -> outputs 1,2,3,4,5 on consecutive cycles, no 6.
- Stream: ready=1, continuous writes of 0..99 -> 100 pops in order, one per cycle, full never asserts, overflow=0.
- Random ready toggling (50%) with random wr_en honouring full -> scoreboard order match; dout stable whenever valid & ~ready; count equals scoreboard depth every cycle.
- Wrap: DEPTH=3 (non-power-of-two), 20 push/pop cycles with occupancy held at 2 -> data intact across pointer wrap.
- Reset mid-stream: rstn low for one cycle while count=3 and valid=1 -> valid, count, full, overflow=0 immediately; first write after release returns new data only.
